// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register with operand selection and forwarding for the ALU.
//   Captures one decoded instruction per cycle and presents alu_a/alu_b/alu_op.
//   rs1/rs2 are forwarded from EX/MEM (first) or MEM/WB (second).
//   A load in EX whose rd is read by the decode instruction stalls decode for
//   one cycle and inserts a bubble. A flush kills both EX and decode.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   id_*                    decoded instruction fields and handshake from decode
//   id_ready                combinational accept (low only on load-use hazard)
//   flush                   kill the instruction in EX and the one in decode
//   mem_wb_en/mem_rd/mem_result   EX/MEM forwarding source
//   wb_en/wb_rd/wb_result         MEM/WB forwarding source
//   ex_valid                EX holds a live instruction
//   alu_a, alu_b, alu_op    ALU operands and op code
//   ex_store_data           forwarded rs2 value for stores
//   ex_rd, ex_wb_en, ex_is_load   registered destination info (enables gated by ex_valid)
module ex_operand_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [XLEN-1:0]     id_rs1_val,
    input  logic [XLEN-1:0]     id_rs2_val,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [XLEN-1:0]     id_imm,
    input  logic                id_sel_a,
    input  logic                id_sel_b,
    input  logic [3:0]          id_alu_op,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_wb_en,
    input  logic                id_is_load,
    input  logic                flush,
    input  logic                mem_wb_en,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic [XLEN-1:0]     mem_result,
    input  logic                wb_en,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic [XLEN-1:0]     wb_result,
    output logic                ex_valid,
    output logic [XLEN-1:0]     alu_a,
    output logic [XLEN-1:0]     alu_b,
    output logic [3:0]          alu_op,
    output logic [XLEN-1:0]     ex_store_data,
    output logic [REG_BITS-1:0] ex_rd,
    output logic                ex_wb_en,
    output logic                ex_is_load
);

    logic                r_valid;
    logic [REG_BITS-1:0] r_rs1;
    logic [REG_BITS-1:0] r_rs2;
    logic [XLEN-1:0]     r_rs1_val;
    logic [XLEN-1:0]     r_rs2_val;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_imm;
    logic                r_sel_a;
    logic                r_sel_b;
    logic [3:0]          r_alu_op;
    logic [REG_BITS-1:0] r_rd;
    logic                r_wb_en;
    logic                r_is_load;

    logic                w_hz;
    logic                w_rs1_hit;
    logic                w_rs2_hit;
    logic [XLEN-1:0]     w_fwd_rs1;
    logic [XLEN-1:0]     w_fwd_rs2;

    // Load-use hazard: the load result is not available until after MEM,
    // so a dependent instruction must wait one cycle.
    always_comb begin
        w_rs1_hit = id_use_rs1 && (id_rs1 == r_rd);
        w_rs2_hit = id_use_rs2 && (id_rs2 == r_rd);
        w_hz      = r_valid && r_is_load && r_wb_en && (r_rd != '0) && id_valid
                    && (w_rs1_hit || w_rs2_hit);
        id_ready  = !w_hz;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_pc      <= '0;
            r_imm     <= '0;
            r_sel_a   <= 1'b0;
            r_sel_b   <= 1'b0;
            r_alu_op  <= '0;
            r_rd      <= '0;
            r_wb_en   <= 1'b0;
            r_is_load <= 1'b0;
        end else if (flush || w_hz) begin
            // Flush takes priority over the stall; both leave a bubble in EX.
            r_valid <= 1'b0;
        end else if (id_valid) begin
            r_valid   <= 1'b1;
            r_rs1     <= id_rs1;
            r_rs2     <= id_rs2;
            r_rs1_val <= id_rs1_val;
            r_rs2_val <= id_rs2_val;
            r_pc      <= id_pc;
            r_imm     <= id_imm;
            r_sel_a   <= id_sel_a;
            r_sel_b   <= id_sel_b;
            r_alu_op  <= id_alu_op;
            r_rd      <= id_rd;
            r_wb_en   <= id_wb_en;
            r_is_load <= id_is_load;
        end else begin
            r_valid <= 1'b0;
        end
    end

    // Forwarding is evaluated every cycle from the registered indices, so a
    // producer reaching EX/MEM or MEM/WB while this instruction sits in EX is
    // still picked up. x0 is never forwarded.
    always_comb begin
        w_fwd_rs1 = r_rs1_val;
        if ((r_rs1 != '0) && mem_wb_en && (mem_rd == r_rs1)) begin
            w_fwd_rs1 = mem_result;
        end else if ((r_rs1 != '0) && wb_en && (wb_rd == r_rs1)) begin
            w_fwd_rs1 = wb_result;
        end

        w_fwd_rs2 = r_rs2_val;
        if ((r_rs2 != '0) && mem_wb_en && (mem_rd == r_rs2)) begin
            w_fwd_rs2 = mem_result;
        end else if ((r_rs2 != '0) && wb_en && (wb_rd == r_rs2)) begin
            w_fwd_rs2 = wb_result;
        end
    end

    assign alu_a         = r_sel_a ? r_pc  : w_fwd_rs1;
    assign alu_b         = r_sel_b ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign alu_op        = r_alu_op;
    assign ex_valid      = r_valid;
    assign ex_rd         = r_rd;
    assign ex_wb_en      = r_valid && r_wb_en;
    assign ex_is_load    = r_valid && r_is_load;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage
//   Directed bench for ex_operand_stage: reset, capture, forwarding priority,
//   load-use stall, flush over stall, and asynchronous reset mid-operation.
module tb_ex_operand_stage;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [31:0] id_rs1_val;
    logic [31:0] id_rs2_val;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic        id_sel_a;
    logic        id_sel_b;
    logic [3:0]  id_alu_op;
    logic [4:0]  id_rd;
    logic        id_wb_en;
    logic        id_is_load;
    logic        flush;
    logic        mem_wb_en;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;
    logic        ex_is_load;

    int unsigned n_pass;
    int unsigned n_total;

    ex_operand_stage #(.XLEN(32), .REG_BITS(5)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_pc(id_pc), .id_imm(id_imm),
        .id_sel_a(id_sel_a), .id_sel_b(id_sel_b),
        .id_alu_op(id_alu_op), .id_rd(id_rd),
        .id_wb_en(id_wb_en), .id_is_load(id_is_load),
        .flush(flush),
        .mem_wb_en(mem_wb_en), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_id();
        id_valid   = 1'b0; id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rs1_val = '0; id_rs2_val = '0; id_pc = '0; id_imm = '0;
        id_sel_a   = 1'b0; id_sel_b = 1'b0; id_alu_op = '0;
        id_rd      = '0; id_wb_en = 1'b0; id_is_load = 1'b0;
    endtask

    task automatic clear_fwd();
        mem_wb_en = 1'b0; mem_rd = '0; mem_result = '0;
        wb_en     = 1'b0; wb_rd  = '0; wb_result  = '0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        flush   = 1'b0;
        clear_id();
        clear_fwd();

        // 1. reset held, then released
        step(); step();
        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_store", ex_store_data, 32'd0);
        check("rst_alu_op", {28'b0, alu_op}, 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("post_rst_id_ready", {31'b0, id_ready}, 32'd1);

        // 2. rs1=3 (5) + imm 7
        id_valid = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_rs1_val = 32'd5;
        id_imm = 32'd7; id_sel_b = 1'b1; id_alu_op = 4'h0; id_rd = 5'd1; id_wb_en = 1'b1;
        step();
        clear_id();
        check("add_ex_valid", {31'b0, ex_valid}, 32'd1);
        check("add_alu_a", alu_a, 32'd5);
        check("add_alu_b", alu_b, 32'd7);
        check("add_ex_rd", {27'b0, ex_rd}, 32'd1);
        check("add_ex_wb_en", {31'b0, ex_wb_en}, 32'd1);
        check("add_ex_is_load", {31'b0, ex_is_load}, 32'd0);

        // 3. forwarding priority on rs1=rs2=4
        id_valid = 1'b1; id_rs1 = 5'd4; id_rs2 = 5'd4; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        id_rs1_val = 32'h11; id_rs2_val = 32'h22; id_alu_op = 4'hA; id_rd = 5'd9;
        id_pc = 32'h1000;
        step();
        clear_id();
        check("bubble_after_idle_ready", {31'b0, id_ready}, 32'd1);
        check("op_passthru", {28'b0, alu_op}, 32'hA);
        check("ex_wb_en_off", {31'b0, ex_wb_en}, 32'd0);
        mem_wb_en = 1'b1; mem_rd = 5'd4; mem_result = 32'hAA;
        wb_en = 1'b1; wb_rd = 5'd4; wb_result = 32'hBB;
        #1;
        check("fwd_mem_a", alu_a, 32'hAA);
        check("fwd_mem_b", alu_b, 32'hAA);
        check("fwd_mem_store", ex_store_data, 32'hAA);
        mem_wb_en = 1'b0;
        #1;
        check("fwd_wb_a", alu_a, 32'hBB);
        check("fwd_wb_store", ex_store_data, 32'hBB);
        mem_wb_en = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
        #1;
        check("fwd_none_a", alu_a, 32'h11);
        check("fwd_none_b", alu_b, 32'h22);
        clear_fwd();
        step();
        check("idle_ex_valid", {31'b0, ex_valid}, 32'd0);

        // x0 is never forwarded even if a stage claims to write it
        id_valid = 1'b1; id_rs1 = 5'd0; id_rs1_val = 32'h0; id_pc = 32'h2000; id_sel_b = 1'b1;
        id_imm = 32'h30;
        step();
        clear_id();
        mem_wb_en = 1'b1; mem_rd = 5'd0; mem_result = 32'hDEAD;
        #1;
        check("x0_no_fwd", alu_a, 32'h0);
        check("x0_imm", alu_b, 32'h30);
        clear_fwd();

        // sel_a = pc
        id_valid = 1'b1; id_sel_a = 1'b1; id_pc = 32'h4444; id_rs1 = 5'd2; id_rs1_val = 32'h9;
        step();
        clear_id();
        check("sel_a_pc", alu_a, 32'h4444);

        // 4. load-use stall on rs2
        id_valid = 1'b1; id_rd = 5'd6; id_wb_en = 1'b1; id_is_load = 1'b1; id_alu_op = 4'h1;
        step();
        check("ld_ex_is_load", {31'b0, ex_is_load}, 32'd1);
        clear_id();
        id_rs2 = 5'd6; id_use_rs2 = 1'b1;
        #1;
        check("ld_ready_no_valid", {31'b0, id_ready}, 32'd1);
        id_valid = 1'b1; id_rs1 = 5'd2; id_use_rs1 = 1'b1; id_rs1_val = 32'h100;
        id_rs2_val = 32'h55; id_rd = 5'd7; id_wb_en = 1'b1; id_alu_op = 4'h2;
        #1;
        check("ld_stall_ready", {31'b0, id_ready}, 32'd0);
        step();
        check("ld_bubble", {31'b0, ex_valid}, 32'd0);
        check("ld_bubble_wb_en", {31'b0, ex_wb_en}, 32'd0);
        check("ld_ready_again", {31'b0, id_ready}, 32'd1);
        step();
        clear_id();
        wb_en = 1'b1; wb_rd = 5'd6; wb_result = 32'h77;
        #1;
        check("ld_accept_valid", {31'b0, ex_valid}, 32'd1);
        check("ld_fwd_a", alu_a, 32'h100);
        check("ld_fwd_b", alu_b, 32'h77);
        check("ld_ex_rd", {27'b0, ex_rd}, 32'd7);
        check("ld_alu_op", {28'b0, alu_op}, 32'h2);
        clear_fwd();

        // load to x0 never stalls
        id_valid = 1'b1; id_rd = 5'd0; id_wb_en = 1'b1; id_is_load = 1'b1;
        step();
        clear_id();
        id_valid = 1'b1; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1;
        check("ld_x0_ready", {31'b0, id_ready}, 32'd1);
        clear_id();

        // 5. flush during a load-use hazard
        id_valid = 1'b1; id_rd = 5'd5; id_wb_en = 1'b1; id_is_load = 1'b1;
        step();
        clear_id();
        id_valid = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rd = 5'd8;
        flush = 1'b1;
        #1;
        check("fl_hz_ready", {31'b0, id_ready}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fl_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("fl_no_stall", {31'b0, id_ready}, 32'd1);
        clear_id();
        step();

        // 6. async reset while EX is live
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_val = 32'h1234; id_rd = 5'd3;
        id_wb_en = 1'b1; id_alu_op = 4'h5;
        step();
        clear_id();
        check("ar_pre_valid", {31'b0, ex_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("ar_alu_a", alu_a, 32'd0);
        check("ar_alu_op", {28'b0, alu_op}, 32'd0);
        check("ar_ex_rd", {27'b0, ex_rd}, 32'd0);
        check("ar_ex_wb_en", {31'b0, ex_wb_en}, 32'd0);
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
